// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the pipeline
// memory stage and the DMA loader.
package dmem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 13;
    localparam int DEFAULT_DATA_W = 32;

    // Who issued the access the memory is answering this cycle.
    typedef struct packed {
        logic valid;
        logic is_dma;
        logic was_read;
    } owner_t;

    function automatic logic owner_read_for(owner_t o, logic want_dma);
        return o.valid & o.was_read & (o.is_dma == want_dma);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive denied-request cycles for one requester;
// 'starved' flags that the requester must win its next contested cycle.
module starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign starved = (cnt_reg >= CNT_W'(LIMIT));

    always_comb begin
        cnt_next = cnt_reg;
        if (!req || gnt) begin
            cnt_next = '0;
        end else if (!starved) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core vs. DMA loader with starvation
// protection, DMA burst lock and read-response routing by owner record.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    // Index 0 = core, index 1 = DMA.
    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic [1:0] starved;

    logic   core_win;
    logic   dma_win;
    logic   lock_active_reg;
    logic   lock_active_next;
    owner_t owner_reg;
    owner_t owner_next;

    assign req_vec = {dma_req, core_req};
    assign gnt_vec = {dma_gnt, core_gnt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_starve
            starve_ctr #(
                .LIMIT(STARVE_LIMIT)
            ) u_starve_ctr (
                .clk    (clk),
                .reset  (reset),
                .req    (req_vec[gi]),
                .gnt    (gnt_vec[gi]),
                .starved(starved[gi])
            );
        end
    endgenerate

    // DMA is checked first so it wins when both counters saturate together.
    always_comb begin
        core_win = 1'b0;
        dma_win  = 1'b0;
        if (core_req && dma_req) begin
            if (starved[1]) begin
                dma_win = 1'b1;
            end else if (starved[0]) begin
                core_win = 1'b1;
            end else if (lock_active_reg) begin
                dma_win = 1'b1;
            end else begin
                core_win = 1'b1;
            end
        end else begin
            core_win = core_req;
            dma_win  = dma_req;
        end
    end

    assign core_gnt   = core_win & ~reset;
    assign dma_gnt    = dma_win & ~reset;
    assign core_stall = core_req & ~core_gnt;

    always_comb begin
        bram_we   = (core_gnt & core_we) | (dma_gnt & dma_we);
        bram_addr = '0;
        bram_din  = '0;
        if (dma_gnt) begin
            bram_addr = dma_addr;
            bram_din  = dma_wdata;
        end else if (core_gnt) begin
            bram_addr = core_addr;
            bram_din  = core_wdata;
        end
    end

    always_comb begin
        lock_active_next = lock_active_reg;
        if (dma_gnt && dma_lock) begin
            lock_active_next = 1'b1;
        end else if (!dma_req || !dma_lock) begin
            lock_active_next = 1'b0;
        end
        owner_next.valid    = core_gnt | dma_gnt;
        owner_next.is_dma   = dma_gnt;
        owner_next.was_read = (core_gnt & ~core_we) | (dma_gnt & ~dma_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_active_reg <= 1'b0;
            owner_reg       <= '0;
        end else begin
            lock_active_reg <= lock_active_next;
            owner_reg       <= owner_next;
        end
    end

    // Gated by reset so a response in flight when reset arrives never escapes.
    assign core_rvalid = owner_read_for(owner_reg, 1'b0) & ~reset;
    assign dma_rvalid  = owner_read_for(owner_reg, 1'b1) & ~reset;
    assign core_rdata  = core_rvalid ? bram_dout : '0;
    assign dma_rdata   = dma_rvalid ? bram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM that
// has a one-cycle registered read.
module tb_dmem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt, core_stall, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dma_req, dma_we, dma_lock;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    dmem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_lock   (dma_lock),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic dma_drive(input logic req, input logic we, input logic lock,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[13'h010] = 32'hDEADBEEF;

        // Reset with both requesters active: everything must stay quiet.
        reset = 1'b1;
        core_drive(1'b1, 1'b1, 13'h055, 32'h11111111);
        dma_drive(1'b1, 1'b0, 1'b0, 13'h066, 32'h0);
        tick(); tick();
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        core_drive(1'b0, 1'b0, '0, '0);
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        tick();
        #1;
        chk("idle_bram_addr", bram_addr, 0);
        chk("idle_bram_din", bram_din, 0);
        chk("idle_bram_we", bram_we, 0);
        $display("txn reset/idle done");

        // Core-only read of preloaded word.
        core_drive(1'b1, 1'b0, 13'h010, '0);
        #1;
        chk("rd_core_gnt", core_gnt, 1);
        chk("rd_core_stall", core_stall, 0);
        chk("rd_bram_addr", bram_addr, 32'h010);
        tick();
        core_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk("rd_core_rvalid", core_rvalid, 1);
        chk("rd_core_rdata", core_rdata, 32'hDEADBEEF);
        chk("rd_dma_rvalid", dma_rvalid, 0);
        tick();
        chk("rd_rvalid_once", core_rvalid, 0);
        chk("rd_rdata_zero", core_rdata, 0);
        $display("txn core read 0x010 -> %h", 32'hDEADBEEF);

        // Core write followed immediately by DMA read of the same word.
        core_drive(1'b1, 1'b1, 13'h020, 32'h12345678);
        #1;
        chk("wr_core_gnt", core_gnt, 1);
        chk("wr_bram_we", bram_we, 1);
        chk("wr_bram_din", bram_din, 32'h12345678);
        tick();
        core_drive(1'b0, 1'b0, '0, '0);
        dma_drive(1'b1, 1'b0, 1'b0, 13'h020, '0);
        #1;
        chk("wr_dma_gnt", dma_gnt, 1);
        chk("wr_no_core_rvalid", core_rvalid, 0);
        tick();
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("wr_dma_rvalid", dma_rvalid, 1);
        chk("wr_dma_rdata", dma_rdata, 32'h12345678);
        chk("wr_core_rvalid", core_rvalid, 0);
        $display("txn core write 0x020 then dma read -> %h", dma_rdata);
        tick();

        // Both requesting, no lock: core 4 cycles, DMA every 5th.
        core_drive(1'b1, 1'b0, 13'h010, '0);
        dma_drive(1'b1, 1'b0, 1'b0, 13'h020, '0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("fair_core_gnt_%0d", k), core_gnt, (k % 5 != 4));
            chk($sformatf("fair_dma_gnt_%0d", k), dma_gnt, (k % 5 == 4));
            chk($sformatf("fair_stall_%0d", k), core_stall, (k % 5 == 4));
            if (k > 0) chk($sformatf("fair_core_rvalid_%0d", k), core_rvalid, ((k - 1) % 5 != 4));
            $display("txn fair cycle %0d core_gnt=%0b dma_gnt=%0b", k, core_gnt, dma_gnt);
            tick();
        end
        core_drive(1'b0, 1'b0, '0, '0);
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Locked DMA burst write, core idle, then core reads back.
        for (int i = 0; i < 8; i++) begin
            dma_drive(1'b1, 1'b1, 1'b1, 13'h100 + 13'(i), 32'hA0000000 + i);
            #1;
            chk($sformatf("burst_gnt_%0d", i), dma_gnt, 1);
            chk($sformatf("burst_addr_%0d", i), bram_addr, 32'h100 + i);
            chk($sformatf("burst_we_%0d", i), bram_we, 1);
            $display("txn dma burst write %h = %h", bram_addr, bram_din);
            tick();
        end
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        core_drive(1'b1, 1'b0, 13'h103, '0);
        #1;
        chk("burst_rd_gnt", core_gnt, 1);
        tick();
        core_drive(1'b0, 1'b0, '0, '0);
        #1;
        chk("burst_rd_rvalid", core_rvalid, 1);
        chk("burst_rd_rdata", core_rdata, 32'hA0000003);
        $display("txn core read 0x103 -> %h", core_rdata);
        tick();

        // Locked DMA burst with core contending: core starved exactly 4 cycles.
        dma_drive(1'b1, 1'b0, 1'b1, 13'h100, '0);
        #1;
        chk("lock_first_dma", dma_gnt, 1);
        tick();
        core_drive(1'b1, 1'b0, 13'h010, '0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("lock_dma_gnt_%0d", k), dma_gnt, (k != 4));
            chk($sformatf("lock_core_gnt_%0d", k), core_gnt, (k == 4));
            chk($sformatf("lock_stall_%0d", k), core_stall, (k != 4));
            $display("txn locked cycle %0d core_gnt=%0b dma_gnt=%0b", k, core_gnt, dma_gnt);
            tick();
        end
        // Dropping dma_lock: still DMA this cycle, lock released for the next.
        dma_lock = 1'b0;
        #1;
        chk("unlock_dma_gnt", dma_gnt, 1);
        tick();
        chk("unlock_core_gnt", core_gnt, 1);
        chk("unlock_dma_denied", dma_gnt, 0);
        core_drive(1'b0, 1'b0, '0, '0);
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick(); tick();

        // Reset right after a granted core read discards the response.
        core_drive(1'b1, 1'b0, 13'h010, '0);
        #1;
        chk("rrst_core_gnt", core_gnt, 1);
        tick();
        core_drive(1'b0, 1'b0, '0, '0);
        dma_drive(1'b1, 1'b1, 1'b0, 13'h030, 32'h5);
        reset = 1'b1;
        #1;
        chk("rrst_core_rvalid", core_rvalid, 0);
        chk("rrst_core_rdata", core_rdata, 0);
        chk("rrst_dma_gnt", dma_gnt, 0);
        chk("rrst_bram_we", bram_we, 0);
        tick();
        reset = 1'b0;
        dma_drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rrst_after_rvalid", core_rvalid, 0);
        chk("rrst_after_dma_rvalid", dma_rvalid, 0);
        $display("txn reset after granted read");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, data-memory word address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied-request cycles after which the starved requester SHALL win.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 core_req / core_we  in  1 / 1  pipeline memory-stage access request / write enable.
REQ-007 core_addr / core_wdata  in  ADDR_W / DATA_W  pipeline address / write data.
REQ-008 core_gnt  out  1  core access accepted this cycle (combinational).
REQ-009 core_stall  out  1  core_req & ~core_gnt; pipeline SHALL hold on it.
REQ-010 core_rvalid / core_rdata  out  1 / DATA_W  core read data valid / data, one cycle after grant.
REQ-011 dma_req / dma_we / dma_lock  in  1 / 1 / 1  loader request / write enable / burst-hold.
REQ-012 dma_addr / dma_wdata  in  ADDR_W / DATA_W  loader address / write data.
REQ-013 dma_gnt / dma_rvalid / dma_rdata  out  1 / 1 / DATA_W  loader grant / read valid / read data.
REQ-014 bram_we / bram_addr / bram_din  out  1 / ADDR_W / DATA_W  single-port data-memory controls.
REQ-015 bram_dout  in  DATA_W  data-memory read data, registered, one-cycle latency.

Function
REQ-016 At most one of core_gnt, dma_gnt SHALL be high in any cycle; grant SHALL require the matching req.
REQ-017 Only one requester active -> that requester SHALL be granted the same cycle.
REQ-018 Both active -> priority order: (a) requester whose starve count >= STARVE_LIMIT; (b) DMA if lock_active; (c) core.
REQ-019 If both starve counts reach the limit in the same cycle, DMA SHALL win.
REQ-020 Per-requester starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle req & ~gnt, and clear on grant or on req low.
REQ-021 lock_active SHALL be set on the clock edge following any DMA grant with dma_lock=1, and cleared when dma_req=0 or dma_lock=0.
REQ-022 bram_we/addr/din SHALL mux from the granted requester; with no grant, bram_we SHALL be 0 and addr/din SHALL hold 0.
REQ-023 An owner register SHALL record {valid, is_dma, was_read} of each granted access; rvalid SHALL assert for exactly one cycle, one cycle after a granted read, to that owner only.
REQ-024 rdata SHALL equal bram_dout when the matching rvalid=1, else 0.
REQ-025 Granted writes SHALL produce no rvalid; a write and a read back-to-back SHALL both complete without an idle cycle.
REQ-026 Core and DMA accessing the same address in consecutive cycles SHALL see program order by grant order (no reordering).

Reset
REQ-027 While reset=1: both grants, bram_we, both rvalid, both rdata SHALL be 0; starve counters, lock_active, owner register SHALL clear.
REQ-028 Reset mid-operation SHALL discard any pending read response; rvalid SHALL be 0 on the first cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the owner-record typedef and the default ADDR_W/DATA_W constants.
REQ-030 A sub-module starve_ctr (saturating counter, one instance per requester) SHALL be used; the rest SHALL live in dmem_arbiter.

Verification
REQ-031 Core-only read of addr 0x010 (preloaded 0xDEADBEEF) -> core_gnt same cycle; core_rvalid=1 with 0xDEADBEEF next cycle; dma_rvalid stays 0.
REQ-032 Both requesting continuously, no lock, STARVE_LIMIT=4 -> core granted 4 cycles, DMA on 5th, repeating; core_stall high only on DMA cycles.
REQ-033 DMA burst write of 8 words 0x100-0x107 with dma_lock=1, core idle, then core reads 0x103 -> returns DMA-written value.
REQ-034 DMA locked burst with core requesting -> core starved exactly 4 cycles, then granted one cycle, then DMA resumes.
REQ-035 Reset asserted the cycle after a granted core read -> no core_rvalid afterwards; all outputs 0 during reset.
REQ-036 Alternating core write 0x020=0x12345678 then DMA read 0x020 in next cycle -> dma_rdata 0x12345678, no idle cycles.
